vx_writeback_collector: RTL

- Receiving end of the writeback channel. Accepts valid-only writeback beats from the commit stage (no backpressure on that channel).
- Buffers beats in a small FIFO and replays them as register-file write requests over a valid/ready port.
- Releases the scoreboard entry for (wis, rd) once the packet's eop beat has been written.
- Checks sop/eop framing per issue warp and reports drops and framing errors through sticky flags.

---
 rtl/vx_writeback_collector.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/vx_writeback_collector.sv
// Writeback collector: buffers commit-stage writeback beats and replays them as register-file
// writes, releases scoreboard entries on eop and checks sop/eop framing per issue warp.
module vx_writeback_collector #(
    parameter int NUM_LANES  = 4,
    parameter int XLEN       = 32,
    parameter int NUM_WIS    = 4,
    parameter int SIMD_IDX_W = 1,
    parameter int NR_BITS    = 6,
    parameter int UUID_WIDTH = 1,
    parameter int DEPTH      = 4,
    parameter int WIS_W      = (NUM_WIS > 1) ? $clog2(NUM_WIS) : 1,
    parameter int CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          wb_valid,
    input  logic [UUID_WIDTH-1:0]         wb_uuid,
    input  logic [WIS_W-1:0]              wb_wis,
    input  logic [SIMD_IDX_W-1:0]         wb_sid,
    input  logic [NUM_LANES-1:0]          wb_tmask,
    input  logic [NR_BITS-1:0]            wb_rd,
    input  logic [NUM_LANES*XLEN-1:0]     wb_data,
    input  logic                          wb_sop,
    input  logic                          wb_eop,
    output logic [CNT_W-1:0]              wb_free,
    output logic                          gpr_wr_valid,
    input  logic                          gpr_wr_ready,
    output logic [UUID_WIDTH-1:0]         gpr_wr_uuid,
    output logic [WIS_W-1:0]              gpr_wr_wis,
    output logic [SIMD_IDX_W-1:0]         gpr_wr_sid,
    output logic [NR_BITS-1:0]            gpr_wr_rd,
    output logic [NUM_LANES-1:0]          gpr_wr_mask,
    output logic [NUM_LANES*XLEN-1:0]     gpr_wr_data,
    output logic                          sb_release_valid,
    output logic [WIS_W-1:0]              sb_release_wis,
    output logic [NR_BITS-1:0]            sb_release_rd,
    output logic                          err_overflow,
    output logic                          err_protocol,
    input  logic                          err_clear
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {IDLE = 1'b0, IN_PKT = 1'b1} frame_state_e;

    logic [UUID_WIDTH-1:0]     mem_uuid  [DEPTH];
    logic [WIS_W-1:0]          mem_wis   [DEPTH];
    logic [SIMD_IDX_W-1:0]     mem_sid   [DEPTH];
    logic [NUM_LANES-1:0]      mem_tmask [DEPTH];
    logic [NR_BITS-1:0]        mem_rd    [DEPTH];
    logic [NUM_LANES*XLEN-1:0] mem_data  [DEPTH];
    logic                      mem_eop   [DEPTH];

    logic [PTR_W-1:0] head, tail;
    logic [CNT_W-1:0] count, count_next;
    frame_state_e     frame_st [NUM_WIS];

    logic full, empty, deq, enq, drop, frame_err;

    // A full FIFO still accepts a beat when the head leaves in the same cycle.
    assign full      = (count == CNT_W'(DEPTH));
    assign empty     = (count == '0);
    assign deq       = !empty && gpr_wr_ready;
    assign enq       = wb_valid && (!full || deq);
    assign drop      = wb_valid && !enq;
    assign frame_err = wb_valid && ((frame_st[wb_wis] == IN_PKT) == wb_sop);

    always_comb begin
        count_next = count + CNT_W'(enq) - CNT_W'(deq);
    end

    assign gpr_wr_valid = !empty;
    assign gpr_wr_uuid  = empty ? '0 : mem_uuid[head];
    assign gpr_wr_wis   = empty ? '0 : mem_wis[head];
    assign gpr_wr_sid   = empty ? '0 : mem_sid[head];
    assign gpr_wr_rd    = empty ? '0 : mem_rd[head];
    assign gpr_wr_mask  = empty ? '0 : mem_tmask[head];
    assign gpr_wr_data  = empty ? '0 : mem_data[head];

    always_ff @(posedge clk) begin
        if (enq) begin
            mem_uuid[tail]  <= wb_uuid;
            mem_wis[tail]   <= wb_wis;
            mem_sid[tail]   <= wb_sid;
            mem_tmask[tail] <= wb_tmask;
            mem_rd[tail]    <= wb_rd;
            mem_data[tail]  <= wb_data;
            mem_eop[tail]   <= wb_eop;
        end
    end

    // Every outcome of the framing check leaves the warp in IN_PKT exactly when eop is low.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head             <= '0;
            tail             <= '0;
            count            <= '0;
            wb_free          <= CNT_W'(DEPTH);
            sb_release_valid <= 1'b0;
            sb_release_wis   <= '0;
            sb_release_rd    <= '0;
            err_overflow     <= 1'b0;
            err_protocol     <= 1'b0;
            for (int i = 0; i < NUM_WIS; i++) begin
                frame_st[i] <= IDLE;
            end
        end else begin
            if (enq) begin
                tail <= tail + PTR_W'(1);
            end
            if (deq) begin
                head <= head + PTR_W'(1);
            end
            count   <= count_next;
            wb_free <= CNT_W'(DEPTH) - count_next;

            sb_release_valid <= deq && mem_eop[head];
            if (deq && mem_eop[head]) begin
                sb_release_wis <= mem_wis[head];
                sb_release_rd  <= mem_rd[head];
            end

            if (wb_valid) begin
                frame_st[wb_wis] <= wb_eop ? IDLE : IN_PKT;
            end

            if (drop) begin
                err_overflow <= 1'b1;
            end else if (err_clear) begin
                err_overflow <= 1'b0;
            end

            if (frame_err) begin
                err_protocol <= 1'b1;
            end else if (err_clear) begin
                err_protocol <= 1'b0;
            end
        end
    end

endmodule
